// File: rtl/uart_rx_if.sv
// uart_rx_if -- serial-receive bundle between a UART receiver and its environment.
//   master : drives rx (serial line) and s_tick (16x baud pulse), observes results
//   slave  : the receiver; returns dout, rx_done_tick, frame_err, parity_err, busy
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic            s_tick;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;
    logic            parity_err;
    logic            busy;

    modport master (
        output rx, s_tick,
        input  dout, rx_done_tick, frame_err, parity_err, busy
    );

    modport slave (
        input  rx, s_tick,
        output dout, rx_done_tick, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 16x-oversampling UART receiver with optional parity.
//   clk, reset : single clock, asynchronous active-high reset
//   bus.rx           : serial line (idles high), synchronized internally
//   bus.s_tick       : one-clk pulse at 16x baud
//   bus.dout         : last received word, LSB first on the line
//   bus.rx_done_tick : one-clk pulse when a frame completes (FIFO write enable)
//   bus.frame_err    : last frame had its stop bit sampled low
//   bus.parity_err   : last frame had a parity mismatch (0 when parity disabled)
//   bus.busy         : receiver is not idle
module uart_rx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input logic     clk,
    input logic     reset,
    uart_rx_if.slave bus
);
    localparam int SW = $clog2(SB_TICK);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            par_q, par_d;
    logic            pend_q, pend_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            fe_q, fe_d;
    logic            pe_q, pe_d;
    logic            rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            par_q   <= 1'b0;
            pend_q  <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            par_q   <= par_d;
            pend_q  <= pend_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], bus.rx};
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        par_d   = par_q;
        pend_d  = pend_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        fe_d    = fe_q;
        pe_d    = pe_q;

        case (state_q)
            IDLE: begin
                // Start detection is tick-independent so a start edge right
                // after a completed frame is never missed.
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (s_q == SW'(7)) begin
                        // Mid start bit: a high line here was a glitch.
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (bus.s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        par_d   = rx_s;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    if (s_q == SW'(15)) pend_d = ~rx_s;
                    if (s_q == SW'(SB_TICK - 1)) begin
                        done_d  = 1'b1;
                        dout_d  = b_q;
                        // With a single stop bit the mid-stop sample and the
                        // end of the stop period fall on the same tick.
                        fe_d    = (s_q == SW'(15)) ? ~rx_s : pend_q;
                        pe_d    = (PARITY_EN != 0) ?
                                  ((^b_q) ^ par_q ^ (PARITY_ODD != 0)) : 1'b0;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from flops so dout is already valid when the
    // FIFO sees its write enable.
    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.frame_err    = fe_q;
    assign bus.parity_err   = pe_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx: three instances (8N1, 8E1, 7N2)
// share clk/reset/s_tick; each has its own serial line.
module tb_uart_rx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if #(.DBIT(8)) if_a ();
    uart_rx_if #(.DBIT(8)) if_b ();
    uart_rx_if #(.DBIT(7)) if_c ();

    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    uart_rx #(.DBIT(7), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));

    int errors = 0;
    int checks = 0;
    int tick_cnt = 0;
    int na = 0, nb = 0, nc = 0;
    int c_done_at = 0;
    logic [7:0] log_a [0:7];

    // Done-pulse monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (if_a.rx_done_tick) begin
            if (na < 8) log_a[na] <= if_a.dout;
            na <= na + 1;
        end
        if (if_b.rx_done_tick) nb <= nb + 1;
        if (if_c.rx_done_tick) begin
            nc        <= nc + 1;
            c_done_at <= tick_cnt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One s_tick every four clocks.
    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) begin
            if_a.s_tick = 1'b1;
            if_b.s_tick = 1'b1;
            if_c.s_tick = 1'b1;
            tick_cnt++;
            step();
            if_a.s_tick = 1'b0;
            if_b.s_tick = 1'b0;
            if_c.s_tick = 1'b0;
            step();
            step();
            step();
        end
    endtask

    task automatic set_rx(input int which, input logic v);
        case (which)
            0: if_a.rx = v;
            1: if_b.rx = v;
            default: if_c.rx = v;
        endcase
    endtask

    task automatic send(input int which, input logic [8:0] data, input int nbits,
                        input bit par_en, input logic par, input logic stop,
                        input int stop_ticks);
        set_rx(which, 1'b0);
        ticks(16);
        for (int i = 0; i < nbits; i++) begin
            set_rx(which, data[i]);
            ticks(16);
        end
        if (par_en) begin
            set_rx(which, par);
            ticks(16);
        end
        set_rx(which, stop);
        ticks(stop_ticks);
        set_rx(which, 1'b1);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int n0;
    int t0;

    initial begin
        if_a.rx = 1'b1; if_b.rx = 1'b1; if_c.rx = 1'b1;
        if_a.s_tick = 1'b0; if_b.s_tick = 1'b0; if_c.s_tick = 1'b0;
        reset = 1'b1;
        step(); step(); step();
        check("rst_dout", 32'(if_a.dout), 32'h0);
        check("rst_done", 32'(if_a.rx_done_tick), 32'h0);
        check("rst_fe", 32'(if_a.frame_err), 32'h0);
        check("rst_pe", 32'(if_b.parity_err), 32'h0);
        check("rst_busy", 32'(if_a.busy), 32'h0);
        reset = 1'b0;
        ticks(4);

        // 8N1 back-to-back 0x55, 0xA3
        n0 = na;
        send(0, 9'h055, 8, 1'b0, 1'b0, 1'b1, 16);
        send(0, 9'h0A3, 8, 1'b0, 1'b0, 1'b1, 16);
        ticks(4);
        check("b2b_count", 32'(na - n0), 32'd2);
        check("b2b_first", 32'(log_a[n0]), 32'h55);
        check("b2b_second", 32'(log_a[n0 + 1]), 32'hA3);
        check("b2b_fe", 32'(if_a.frame_err), 32'h0);
        check("b2b_pe", 32'(if_a.parity_err), 32'h0);

        // 0x3C with low stop bit, then good 0x11
        n0 = na;
        send(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 8);
        ticks(12);
        check("fe_count", 32'(na - n0), 32'd1);
        check("fe_dout", 32'(if_a.dout), 32'h3C);
        check("fe_flag", 32'(if_a.frame_err), 32'h1);
        check("fe_idle", 32'(if_a.busy), 32'h0);
        send(0, 9'h011, 8, 1'b0, 1'b0, 1'b1, 16);
        ticks(4);
        check("fe_next_count", 32'(na - n0), 32'd2);
        check("fe_next_dout", 32'(if_a.dout), 32'h11);
        check("fe_next_flag", 32'(if_a.frame_err), 32'h0);

        // glitch: low for 4 ticks
        n0 = na;
        if_a.rx = 1'b0;
        ticks(4);
        if_a.rx = 1'b1;
        ticks(2);
        check("glitch_busy_mid", 32'(if_a.busy), 32'h1);
        ticks(3);
        check("glitch_busy_end", 32'(if_a.busy), 32'h0);
        ticks(8);
        check("glitch_no_done", 32'(na - n0), 32'd0);
        check("glitch_dout_held", 32'(if_a.dout), 32'h11);

        // even parity on instance B
        n0 = nb;
        send(1, 9'h007, 8, 1'b1, 1'b1, 1'b1, 16);
        ticks(4);
        check("par_ok_count", 32'(nb - n0), 32'd1);
        check("par_ok_dout", 32'(if_b.dout), 32'h07);
        check("par_ok_pe", 32'(if_b.parity_err), 32'h0);
        check("par_ok_fe", 32'(if_b.frame_err), 32'h0);
        send(1, 9'h007, 8, 1'b1, 1'b0, 1'b1, 16);
        ticks(4);
        check("par_bad_count", 32'(nb - n0), 32'd2);
        check("par_bad_pe", 32'(if_b.parity_err), 32'h1);

        // reset mid-frame, then 0x81
        n0 = na;
        if_a.rx = 1'b0;
        ticks(16);
        if_a.rx = 1'b1;
        ticks(64);
        check("mid_busy", 32'(if_a.busy), 32'h1);
        reset = 1'b1;
        step();
        check("mid_rst_busy", 32'(if_a.busy), 32'h0);
        check("mid_rst_dout", 32'(if_a.dout), 32'h0);
        step();
        reset = 1'b0;
        ticks(20);
        check("mid_no_done", 32'(na - n0), 32'd0);
        send(0, 9'h081, 8, 1'b0, 1'b0, 1'b1, 16);
        ticks(4);
        check("mid_after_count", 32'(na - n0), 32'd1);
        check("mid_after_dout", 32'(if_a.dout), 32'h81);

        // 7 data bits, 2 stop bits, latency
        n0 = nc;
        t0 = tick_cnt;
        send(2, 9'h05A, 7, 1'b0, 1'b0, 1'b1, 32);
        ticks(4);
        check("c_count", 32'(nc - n0), 32'd1);
        check("c_dout", 32'(if_c.dout), 32'h5A);
        check("c_fe", 32'(if_c.frame_err), 32'h0);
        check("c_latency", 32'(c_done_at - t0 - 1), 32'd152);

        // break: line held low
        n0 = na;
        if_a.rx = 1'b0;
        ticks(158);
        check("brk_count", 32'(na - n0), 32'd1);
        check("brk_dout", 32'(if_a.dout), 32'h0);
        check("brk_fe", 32'(if_a.frame_err), 32'h1);
        check("brk_restart", 32'(if_a.busy), 32'h1);
        if_a.rx = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        ticks(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter DBIT, default 8, number of data bits per frame (5..9).
REQ-002 The module SHALL have parameter SB_TICK, default 16, stop-bit length in oversampling ticks (16, 24 or 32 for 1, 1.5 or 2 stop bits).
REQ-003 The module SHALL have parameter PARITY_EN, default 0; 1 means one parity bit follows the data bits.
REQ-004 The module SHALL have parameter PARITY_ODD, default 0; 0 means even parity and 1 means odd parity; used only when PARITY_EN=1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 rx  input  1  asynchronous serial line; idles high.
REQ-008 s_tick  input  1  one-clk-wide pulse at 16x baud rate from the baud generator.
REQ-009 dout  output  DBIT  last received data word, LSB received first; drives the RX FIFO write-data input.
REQ-010 rx_done_tick  output  1  one-clk pulse when a frame completes; drives the RX FIFO w_en.
REQ-011 frame_err  output  1  status of the last completed frame: stop bit sampled low.
REQ-012 parity_err  output  1  status of the last completed frame: parity mismatch; held 0 when PARITY_EN=0.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer, both flops reset to 1; all sampling below uses the synchronized value (rx_s).
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-016 A tick counter s SHALL be wide enough to hold SB_TICK-1; a bit counter n SHALL be wide enough to hold DBIT-1.
REQ-017 s, n, the shift register and the state SHALL change only on s_tick cycles, except the IDLE->START transition.
REQ-018 IDLE: when rx_s==0, go to START with s=0; this transition does not wait for s_tick.
REQ-019 START: on s_tick with s==7 (mid start bit): if rx_s==0, go to DATA with s=0 and n=0; if rx_s==1, return to IDLE as glitch rejection, with no output change. Otherwise increment s on s_tick.
REQ-020 DATA: on s_tick with s==15: set s=0 and shift in rx_s at the MSB, right-shifting so the first bit lands in bit 0 after DBIT shifts.
REQ-021 DATA, continued: if n==DBIT-1, go to PARITY when PARITY_EN=1, otherwise to STOP; else increment n.
REQ-022 PARITY: on s_tick with s==15: set s=0, capture rx_s as the parity bit and go to STOP.
REQ-023 Parity SHALL be computed as XOR of the data bits, XOR the parity bit, XOR PARITY_ODD; a nonzero result is a mismatch.
REQ-024 STOP: on s_tick with s==15, record frame_pending = ~rx_s.
REQ-025 STOP: on s_tick with s==SB_TICK-1, in the same cycle: assert rx_done_tick for exactly one clk, load dout, frame_err and parity_err, and go to IDLE.
REQ-026 rx_done_tick SHALL be asserted even when frame_err or parity_err is set; the FIFO stores the word regardless.
REQ-027 dout, frame_err and parity_err SHALL hold their values until the next rx_done_tick.
REQ-028 Latency: rx_done_tick SHALL occur on the s_tick cycle that ends the stop period, (1 + DBIT + PARITY_EN)*16 + SB_TICK - 8 ticks after start detection, within ±1 tick.
REQ-029 A start bit falling on the same cycle as return to IDLE SHALL be detected one clk later in IDLE; back-to-back frames SHALL not be lost.
REQ-030 s_tick absent means no progress; the FSM SHALL remain in its state indefinitely without timeout.
REQ-031 A break condition (rx held low) SHALL complete a frame with dout=0 and frame_err=1, then restart at START while rx stays low.

Reset
REQ-032 On reset assertion, asynchronously: state=IDLE, s=0, n=0, shift register=0, dout=0, rx_done_tick=0, frame_err=0, parity_err=0, busy=0, synchronizer flops=1.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; no rx_done_tick SHALL follow its release until a new full frame arrives.

Verification
REQ-034 8N1, send 0x55, then 0xA3 back-to-back -> two rx_done_tick pulses; dout=0x55, then 0xA3; frame_err=0; parity_err=0.
REQ-035 Send 0x3C with stop bit driven low -> rx_done_tick asserted, dout=0x3C, frame_err=1; next good frame 0x11 -> frame_err=0.
REQ-036 rx low for 4 ticks then high (glitch) -> no rx_done_tick; busy returns to 0 by tick 8.
REQ-037 PARITY_EN=1, PARITY_ODD=0: 0x07 with parity bit 1 -> parity_err=0; 0x07 with parity bit 0 -> parity_err=1.
REQ-038 Reset pulse after 4 data bits of 0xFF, then send 0x81 -> exactly one rx_done_tick, dout=0x81.
REQ-039 DBIT=7, SB_TICK=32, send 0x5A -> rx_done_tick at the latency given by REQ-028, dout=0x5A.
